// File: rtl/stopwatch_ctrl_if.sv
// Button and status bundle for stopwatch_ctrl. The master drives the button
// pulses and observes the status; the controller implements the slave side.
interface stopwatch_if;
  logic       btn_run;
  logic       btn_clear;
  logic       btn_lap;
  logic       run;
  logic       clear;
  logic       tick;
  logic       hold;
  logic [1:0] state;

  modport master (
    output btn_run, btn_clear, btn_lap,
    input  run, clear, tick, hold, state
  );

  modport slave (
    input  btn_run, btn_clear, btn_lap,
    output run, clear, tick, hold, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/clear controller with tick prescaler and lap hold.
// Every output is a flop; the state register is visible on sw.state.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  stopwatch_if.slave  sw
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_e;

  // Held as plain bits so the unused 2'b11 encoding stays representable.
  logic [1:0]    state_q, state_d;
  logic          run_q, run_d;
  logic          clear_q, clear_d;
  logic          tick_q, tick_d;
  logic          hold_q, hold_d;
  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    state_d = ST_STOP;
    case (state_q)
      ST_STOP: begin
        if (sw.btn_clear)    state_d = ST_CLEAR;
        else if (sw.btn_run) state_d = ST_RUN;
        else                 state_d = ST_STOP;
      end
      ST_RUN:   state_d = sw.btn_run ? ST_STOP : ST_RUN;
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  // run/clear are decoded from the next state so they line up with state.
  always_comb begin
    run_d   = (state_d == ST_RUN);
    clear_d = (state_d == ST_CLEAR);
  end

  // Prescaler advances only from RUN and freezes elsewhere to keep tick phase.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    hold_d  = hold_q;
    if (state_q == ST_RUN) begin
      if (presc_q == LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
      if (sw.btn_lap) hold_d = ~hold_q;
    end else if (state_q == ST_CLEAR) begin
      presc_d = '0;
      hold_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_STOP;
      run_q   <= 1'b0;
      clear_q <= 1'b0;
      tick_q  <= 1'b0;
      hold_q  <= 1'b0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      clear_q <= clear_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
      presc_q <= presc_d;
    end
  end

  assign sw.state = state_q;
  assign sw.run   = run_q;
  assign sw.clear = clear_q;
  assign sw.tick  = tick_q;
  assign sw.hold  = hold_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4: directed scenarios followed by
// random button traffic, all checked against a cycle-level reference model.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;

  // Reference model: mode 0=stopped 1=running 2=clearing 3=illegal.
  int   m_st;
  int   m_cnt;
  int   m_hold;
  int   m_tick;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  stopwatch_if sw_if ();

  stopwatch_ctrl #(.TICK_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input logic r, input logic c, input logic l, input logic rs);
    int nxt;
    if (!rs) begin
      m_st = 0; m_cnt = 0; m_hold = 0; m_tick = 0;
    end else begin
      m_tick = 0;
      if (m_st == 1) begin
        m_cnt  = (m_cnt + 1) % DIV;
        m_tick = (m_cnt == 0) ? 1 : 0;
        if (l) m_hold = 1 - m_hold;
      end else if (m_st == 2) begin
        m_cnt  = 0;
        m_hold = 0;
      end
      if (m_st == 0)      nxt = c ? 2 : (r ? 1 : 0);
      else if (m_st == 1) nxt = r ? 0 : 1;
      else                nxt = 0;
      m_st = nxt;
    end
  endtask

  task automatic check_all();
    chk("state", 32'(sw_if.state), 32'(m_st));
    chk("run",   32'(sw_if.run),   32'(m_st == 1));
    chk("clear", 32'(sw_if.clear), 32'(m_st == 2));
    chk("tick",  32'(sw_if.tick),  32'(m_tick));
    chk("hold",  32'(sw_if.hold),  32'(m_hold));
    chk("presc", 32'(dut.presc_q), 32'(m_cnt));
  endtask

  // Driver: inputs change on the falling edge, outputs sampled 1ns after rise.
  task automatic step(input logic r, input logic c, input logic l, input logic rs);
    @(negedge clk);
    sw_if.btn_run   = r;
    sw_if.btn_clear = c;
    sw_if.btn_lap   = l;
    rst             = rs;
    @(posedge clk);
    model_edge(r, c, l, rs);
    #1;
    check_all();
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int first;
    int nt;
    int guard;
    tests = 0; fails = 0; cyc = 0;
    m_st = 0; m_cnt = 0; m_hold = 0; m_tick = 0;
    rst = 1'b0;
    sw_if.btn_run = 1'b0; sw_if.btn_clear = 1'b0; sw_if.btn_lap = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_state", 32'(sw_if.state), 32'd0);

    // Start and tick cadence: ticks after E4, E8, E12
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("run_after_e0", 32'(sw_if.run), 32'd1);
    got_q.delete();
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (sw_if.tick) got_q.push_back(8'(i));
    end
    exp_q = '{8'd4, 8'd8, 8'd12};
    chk("tick_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("tick_pos", 32'(got_q[i]), 32'(exp_q[i]));

    // Stop after two counts, idle, resume: tick two edges after resume
    idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("stopped_presc", 32'(dut.presc_q), 32'd2);
    nt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (sw_if.tick) nt++;
    end
    chk("no_tick_stopped", 32'(nt), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (sw_if.tick && first == 0) first = k;
    end
    chk("resume_phase", 32'(first), 32'd2);

    // Stop, then run+clear together in STOP -> one CLEAR cycle
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_state", 32'(sw_if.state), 32'd2);
    chk("clr_pulse", 32'(sw_if.clear), 32'd1);
    idle(1);
    chk("after_clr_state", 32'(sw_if.state), 32'd0);
    chk("after_clr_presc", 32'(dut.presc_q), 32'd0);
    chk("after_clr_run",   32'(sw_if.run), 32'd0);

    // Clear ignored in RUN, lap sets hold, stop+clear drops hold
    step(1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("clr_ignored", 32'(sw_if.state), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("lap_hold", 32'(sw_if.hold), 32'd1);
    idle(5);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("lap_ignored_stop", 32'(sw_if.hold), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("hold_kept_rerun", 32'(sw_if.hold), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("run_lap_state", 32'(sw_if.state), 32'd0);
    chk("run_lap_hold",  32'(sw_if.hold), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_hold", 32'(sw_if.hold), 32'd0);

    // Stop on the wrap edge: exactly one tick
    step(1'b1, 1'b0, 1'b0, 1'b1);
    guard = 0;
    while (m_cnt != DIV - 1 && guard < 8) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    chk("wrap_reached", 32'(guard < 8), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("wrap_tick", 32'(sw_if.tick), 32'd1);
    chk("wrap_stop", 32'(sw_if.state), 32'd0);
    nt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (sw_if.tick) nt++;
    end
    chk("wrap_no_more", 32'(nt), 32'd0);
    chk("wrap_presc", 32'(dut.presc_q), 32'd0);

    // Reset mid-RUN with hold set
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_run",  32'(sw_if.run), 32'd0);
    chk("rst_hold", 32'(sw_if.hold), 32'd0);
    chk("rst_presc", 32'(dut.presc_q), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("first_btn_after_rst", 32'(sw_if.state), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Illegal encoding recovers to STOP in one edge
    force dut.state_q = 2'b11;
    #1;
    release dut.state_q;
    m_st = 3;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("illegal_recover", 32'(sw_if.state), 32'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 99) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: TICK_DIV, default 1000000, clk cycles per tick period (100 Hz at 100 MHz); legal values >= 2.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  one clock; reset is synchronous and active-low.
REQ-004 Port: btn_run  input  1  debounced run/stop request, one-cycle pulse.
REQ-005 Port: btn_clear  input  1  debounced clear request, one-cycle pulse.
REQ-006 Port: btn_lap  input  1  debounced lap (display freeze) request, one-cycle pulse.
REQ-007 Port: run  output  1  high while FSM is in RUN.
REQ-008 Port: clear  output  1  one-cycle pulse commanding downstream counters to zero.
REQ-009 Port: tick  output  1  one-cycle count-enable pulse, TICK_DIV-cycle period while running.
REQ-010 Port: hold  output  1  display freeze; counting continues underneath.
REQ-011 Port: state  output  2  current FSM state encoding.

Function
REQ-012 The FSM SHALL have three states: STOP=2'b00, RUN=2'b01, CLEAR=2'b10; 2'b11 SHALL transition to STOP on the next edge.
REQ-013 STOP: btn_clear -> CLEAR; else btn_run -> RUN; else stay. btn_clear has priority when both are high.
REQ-014 RUN: btn_run -> STOP; btn_clear SHALL be ignored; else stay.
REQ-015 CLEAR SHALL last exactly one cycle, then go to STOP unconditionally; all buttons are ignored while in CLEAR.
REQ-016 All outputs SHALL be registered; a button sampled at edge N SHALL be reflected on state/run after edge N.
REQ-017 clear SHALL be high exactly for the cycle in which state==CLEAR.
REQ-018 The prescaler SHALL be $clog2(TICK_DIV) bits wide.
REQ-019 The prescaler SHALL increment on each edge where the registered state is RUN.
REQ-020 The prescaler SHALL hold its value in STOP, so that resuming preserves tick phase.
REQ-021 The prescaler SHALL be zeroed on the edge where the registered state is CLEAR.
REQ-022 On an edge with registered state RUN and prescaler==TICK_DIV-1, the prescaler SHALL wrap to 0 and tick SHALL be set to 1; on all other edges tick SHALL be set to 0.
REQ-023 If btn_run (stop) coincides with a wrap edge, the tick SHALL still be issued and the prescaler SHALL hold 0 in STOP.
REQ-024 hold SHALL toggle on btn_lap only while the registered state is RUN; btn_lap in STOP or CLEAR SHALL be ignored.
REQ-025 hold SHALL retain its value across RUN->STOP->RUN transitions.
REQ-026 hold SHALL be forced to 0 on the edge where the registered state is CLEAR.
REQ-027 Simultaneous btn_run and btn_lap in RUN SHALL both take effect: the FSM goes to STOP and hold toggles.

Reset
REQ-028 When rst==0 at a rising edge, the block SHALL set state=STOP, prescaler=0, run=0, clear=0, tick=0, hold=0.
REQ-029 Reset SHALL override all button inputs, including mid-RUN and mid-CLEAR.
REQ-030 After rst returns high, the first button SHALL be accepted on the first edge.

Verification (TICK_DIV=4)
REQ-031 Release reset, pulse btn_run at edge E0 -> run=1 after E0; tick high only in the cycles after E4, E8, E12.
REQ-032 Run, then pulse btn_run after 2 prescaler counts; wait 10 cycles; pulse btn_run -> no tick while stopped; the next tick comes 2 edges after resume.
REQ-033 In STOP, pulse btn_run and btn_clear together -> state=CLEAR for one cycle with clear=1, then STOP with prescaler=0; run stays 0.
REQ-034 In RUN, pulse btn_clear -> ignored, ticks continue; pulse btn_lap -> hold=1; stop, then clear -> hold=0.
REQ-035 Stop on the wrap edge -> a single tick is emitted and no further ticks follow.
REQ-036 Assert rst=0 mid-RUN with hold=1 -> all outputs 0 and state=STOP after that edge; force state to 2'b11 -> STOP after one edge.
